// File: rtl/fprti_issue_seq_if.sv
// Bundle of CPU-side and core-side signals for the FPRTI issue sequencer.
// The master side is the CPU/core environment; the slave side is the sequencer.
interface fprti_issue_seq_if #(
   parameter int NUM_FPRTI_REGS = 16,
   parameter int IDX_W          = $clog2(NUM_FPRTI_REGS)
);
   logic                             wr_valid;
   logic [IDX_W-1:0]                 wr_idx;
   logic [31:0]                      wr_data;
   logic                             wr_ready;
   logic                             start;
   logic                             busy;
   logic [NUM_FPRTI_REGS-1:0][31:0]  fprti_regs;
   logic                             input_valid;
   logic [31:0]                      core_return;
   logic                             core_valid;
   logic                             rsp_valid;
   logic [31:0]                      rsp_data;
   logic                             rsp_timeout;
   logic                             rsp_ready;

   modport master (
      output wr_valid, wr_idx, wr_data, start, core_return, core_valid, rsp_ready,
      input  wr_ready, busy, fprti_regs, input_valid, rsp_valid, rsp_data, rsp_timeout
   );

   modport slave (
      input  wr_valid, wr_idx, wr_data, start, core_return, core_valid, rsp_ready,
      output wr_ready, busy, fprti_regs, input_valid, rsp_valid, rsp_data, rsp_timeout
   );
endinterface

// File: rtl/fprti_issue_seq.sv
// Front-end sequencer: owns the FPRTI register file, launches the intersection core,
// waits for its result (with timeout) and presents it in a valid/ready response slot.
module fprti_issue_seq #(
   parameter int NUM_FPRTI_REGS = 16,
   parameter int IDX_W          = $clog2(NUM_FPRTI_REGS),
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input logic              clk,
   input logic              rst_n,
   fprti_issue_seq_if.slave bus
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                            state;
   logic [NUM_FPRTI_REGS-1:0][31:0]   regs;
   logic [TO_W-1:0]                   timer;
   logic                              wr_ready;
   logic                              busy;
   logic                              input_valid;
   logic                              rsp_valid;
   logic [31:0]                       rsp_data;
   logic                              rsp_timeout;

   // NOTE: the register file is reset because the core sees it directly and
   // must never observe power-up garbage; this costs a reset net per flop.
   // NOTE: every state element below uses non-blocking assignment so all
   // updates see pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         regs        <= '0;
         timer       <= '0;
         wr_ready    <= 1'b1;
         busy        <= 1'b0;
         input_valid <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // Out-of-range indices are accepted but dropped.
               if (bus.wr_valid && (int'(bus.wr_idx) < NUM_FPRTI_REGS))
                  regs[bus.wr_idx] <= bus.wr_data;
               if (bus.start) begin
                  state       <= ISSUE;
                  wr_ready    <= 1'b0;
                  busy        <= 1'b1;
                  input_valid <= 1'b1;
               end
            end
            ISSUE: begin
               input_valid <= 1'b0;
               timer       <= '0;
               state       <= WAIT;
            end
            WAIT: begin
               timer <= timer + TO_W'(1);
               // A core result arriving on the timeout cycle takes priority.
               if (bus.core_valid) begin
                  rsp_data    <= bus.core_return;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (timer == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data    <= QNAN;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  wr_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.fprti_regs  = regs;
   assign bus.wr_ready    = wr_ready;
   assign bus.busy        = busy;
   assign bus.input_valid = input_valid;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.rsp_data    = rsp_data;
   assign bus.rsp_timeout = rsp_timeout;

endmodule

// File: tb/tb_fprti_issue_seq.sv
// Directed bench for fprti_issue_seq: a table-driven launch/response sequence plus
// hand-written sequences for timeout, same-cycle write+start, range drop and async reset.
module tb_fprti_issue_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fprti_issue_seq_if #(.NUM_FPRTI_REGS(16)) bus ();
   fprti_issue_seq_if #(.NUM_FPRTI_REGS(12), .IDX_W(4)) bus2 ();

   fprti_issue_seq #(.NUM_FPRTI_REGS(16), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   fprti_issue_seq #(.NUM_FPRTI_REGS(12), .IDX_W(4), .TIMEOUT_CYCLES(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
   );

   typedef struct {
      logic        wr_valid;
      logic [3:0]  wr_idx;
      logic [31:0] wr_data;
      logic        start;
      logic        core_valid;
      logic [31:0] core_return;
      logic        rsp_ready;
      logic        e_wr_ready;
      logic        e_busy;
      logic        e_iv;
      logic        e_rv;
      logic [31:0] e_data;
      logic        e_to;
   } vec_t;

   vec_t        vecs [17];
   logic [31:0] flt  [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_valid = 0; bus.wr_idx = '0; bus.wr_data = '0; bus.start = 0;
      bus.core_valid = 0; bus.core_return = '0; bus.rsp_ready = 0;
   endtask

   function automatic vec_t mk(input logic wv, input logic [3:0] wi, input logic [31:0] wd,
                               input logic st, input logic cv, input logic [31:0] cr,
                               input logic rr, input logic ewr, input logic eb,
                               input logic eiv, input logic erv, input logic [31:0] ed,
                               input logic eto);
      vec_t v;
      v.wr_valid = wv; v.wr_idx = wi; v.wr_data = wd; v.start = st;
      v.core_valid = cv; v.core_return = cr; v.rsp_ready = rr;
      v.e_wr_ready = ewr; v.e_busy = eb; v.e_iv = eiv; v.e_rv = erv;
      v.e_data = ed; v.e_to = eto;
      return v;
   endfunction

   initial begin
      int nz;
      flt = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
              32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
              32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};

      // Launch, 8 WAIT cycles with ignored writes/starts, core answers on the
      // timeout cycle (timer==7), response held 5 cycles, then released.
      vecs[0] = mk(0, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0);
      for (int i = 1; i <= 8; i++)
         vecs[i] = mk(1, 5, 32'hDEAD_BEEF, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
      vecs[9] = mk(0, 0, 0, 0, 1, 32'h4040_0000, 0,  0, 1, 0, 1, 32'h4040_0000, 0);
      for (int i = 10; i <= 14; i++)
         vecs[i] = mk(1, 5, 32'hDEAD_BEEF, 1, 1, 32'h1111_1111, 0,
                      0, 1, 0, 1, 32'h4040_0000, 0);
      vecs[15] = mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
      vecs[16] = mk(0, 0, 0, 0, 1, 32'h2222_2222, 0,  1, 0, 0, 0, 0, 0);

      idle_inputs();
      bus2.wr_valid = 0; bus2.wr_idx = '0; bus2.wr_data = '0; bus2.start = 0;
      bus2.core_valid = 0; bus2.core_return = '0; bus2.rsp_ready = 0;

      #12;
      check("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_iv", 32'(bus.input_valid), 32'd0);
      check("reset_reg0", bus.fprti_regs[0], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Load idx0..14 with 1.0..15.0.
      for (int i = 0; i < 15; i++) begin
         bus.wr_valid = 1; bus.wr_idx = 4'(i); bus.wr_data = flt[i];
         step();
      end
      idle_inputs();
      check("load_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("load_reg14", bus.fprti_regs[14], 32'h4170_0000);

      for (int i = 0; i < 17; i++) begin
         bus.wr_valid = vecs[i].wr_valid; bus.wr_idx = vecs[i].wr_idx;
         bus.wr_data = vecs[i].wr_data; bus.start = vecs[i].start;
         bus.core_valid = vecs[i].core_valid; bus.core_return = vecs[i].core_return;
         bus.rsp_ready = vecs[i].rsp_ready;
         step();
         check($sformatf("v%0d_wr_ready", i), 32'(bus.wr_ready), 32'(vecs[i].e_wr_ready));
         check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
         check($sformatf("v%0d_iv", i), 32'(bus.input_valid), 32'(vecs[i].e_iv));
         check($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].e_rv));
         if (vecs[i].e_rv) begin
            check($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].e_data);
            check($sformatf("v%0d_rsp_to", i), 32'(bus.rsp_timeout), 32'(vecs[i].e_to));
         end
         if (vecs[i].e_iv)
            check($sformatf("v%0d_reg14_at_launch", i), bus.fprti_regs[14], 32'h4170_0000);
      end
      idle_inputs();
      check("ignored_write_reg5", bus.fprti_regs[5], 32'h40C0_0000);
      check("regs_kept_reg0", bus.fprti_regs[0], 32'h3F80_0000);

      // Timeout: core silent, RESP appears on the 9th edge after launch.
      bus.start = 1;
      step();
      bus.start = 0;
      check("to_iv", 32'(bus.input_valid), 32'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("to_wait%0d_rv", i), 32'(bus.rsp_valid), 32'd0);
      end
      step();
      check("to_rv", 32'(bus.rsp_valid), 32'd1);
      check("to_data", bus.rsp_data, 32'h7FC0_0000);
      check("to_flag", 32'(bus.rsp_timeout), 32'd1);
      bus.rsp_ready = 1;
      step();
      bus.rsp_ready = 0;
      check("to_back_idle", 32'(bus.wr_ready), 32'd1);

      // Same-cycle write and start; minimum 4-cycle round trip.
      bus.wr_valid = 1; bus.wr_idx = 3; bus.wr_data = 32'hBF80_0000; bus.start = 1;
      step();
      idle_inputs();
      check("ws_iv", 32'(bus.input_valid), 32'd1);
      check("ws_reg3", bus.fprti_regs[3], 32'hBF80_0000);
      bus.core_valid = 1; bus.core_return = 32'h4080_0000; bus.rsp_ready = 1;
      step();
      step();
      bus.core_valid = 0;
      check("ws_rv", 32'(bus.rsp_valid), 32'd1);
      check("ws_data", bus.rsp_data, 32'h4080_0000);
      step();
      bus.rsp_ready = 0;
      check("ws_round_trip", 32'(bus.wr_ready), 32'd1);

      // Top index accepted.
      bus.wr_valid = 1; bus.wr_idx = 15; bus.wr_data = 32'h4180_0000;
      step();
      idle_inputs();
      check("idx15", bus.fprti_regs[15], 32'h4180_0000);

      // Out-of-range index dropped on a 12-entry instance.
      bus2.wr_valid = 1; bus2.wr_idx = 11; bus2.wr_data = 32'h1234_5678;
      step();
      bus2.wr_idx = 13; bus2.wr_data = 32'hFFFF_FFFF;
      step();
      bus2.wr_valid = 0;
      check("small_idx11", bus2.fprti_regs[11], 32'h1234_5678);
      nz = 0;
      for (int i = 0; i < 11; i++) if (bus2.fprti_regs[i] != 0) nz++;
      check("small_oob_dropped", 32'(nz), 32'd0);

      // Asynchronous reset during WAIT.
      bus.start = 1;
      step();
      bus.start = 0;
      step();
      step();
      check("ar_busy_before", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("ar_busy", 32'(bus.busy), 32'd0);
      check("ar_reg3", bus.fprti_regs[3], 32'd0);
      step();
      rst_n = 1'b1;
      bus.core_valid = 1; bus.core_return = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("ar_no_rsp%0d", i), 32'(bus.rsp_valid), 32'd0);
      end
      bus.core_valid = 0;
      check("ar_reg14", bus.fprti_regs[14], 32'd0);
      bus.start = 1;
      step();
      bus.start = 0;
      check("ar_new_iv", 32'(bus.input_valid), 32'd1);
      step();
      check("ar_new_iv_drop", 32'(bus.input_valid), 32'd0);
      bus.core_valid = 1; bus.core_return = 32'h40A0_0000;
      step();
      bus.core_valid = 0;
      check("ar_new_rv", 32'(bus.rsp_valid), 32'd1);
      check("ar_new_data", bus.rsp_data, 32'h40A0_0000);
      check("ar_new_to", 32'(bus.rsp_timeout), 32'd0);
      bus.rsp_ready = 1;
      step();
      bus.rsp_ready = 0;
      check("ar_new_idle", 32'(bus.rsp_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
